// File: rtl/sim_bus_pkg.sv
// Shared constants and helpers for the sim control-bus arbiter.
// Provides bus widths and the round-robin successor function.
package sim_bus_pkg;

    localparam int BUS_AW  = 32;
    localparam int BUS_DW  = 32;
    localparam int BUS_BEW = 4;

    // Successor of cur in 0..n-1, wrapping explicitly so n
    // need not be a power of two.
    function automatic int unsigned rr_next(
        input int unsigned cur,
        input int unsigned n
    );
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of granted master IDs awaiting a slave response.
// Ports: clk_i, rst_i, push_i/din_i, pop_i, full_o, empty_o, head_o.
module arb_id_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q <= (wr_q == PW'(DEPTH - 1))
                      ? '0 : wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= (rd_q == PW'(DEPTH - 1))
                      ? '0 : rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sim_bus_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid slave among masters.
// Ports: m_* per-master lanes (packed, lane k at [k*W+:W]), s_* slave.
module sim_bus_arbiter
    import sim_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_OUTST   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_MASTERS-1:0]        m_req_i,
    output logic [NUM_MASTERS-1:0]        m_gnt_o,
    input  logic [NUM_MASTERS*BUS_AW-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*BUS_BEW-1:0] m_be_i,
    input  logic [NUM_MASTERS*BUS_DW-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]        m_rvalid_o,
    output logic [NUM_MASTERS*BUS_DW-1:0] m_rdata_o,
    output logic                          s_req_o,
    input  logic                          s_gnt_i,
    output logic [BUS_AW-1:0]             s_addr_o,
    output logic                          s_we_o,
    output logic [BUS_BEW-1:0]            s_be_o,
    output logic [BUS_DW-1:0]             s_wdata_o,
    input  logic                          s_rvalid_i,
    input  logic [BUS_DW-1:0]             s_rdata_i
);

    localparam int IDW = (NUM_MASTERS > 1)
                       ? $clog2(NUM_MASTERS) : 1;

    logic [IDW-1:0] ptr_q;
    logic           lock_q;
    logic [IDW-1:0] lock_id_q;
    logic           err_q;

    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    logic           found;
    logic           xfer;
    logic           fifo_full;
    logic           fifo_empty;
    logic [IDW-1:0] fifo_head;
    logic           pop;

    // Scan from the rr pointer; a pending ungranted request
    // pins the selection until the slave takes it.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && m_req_i[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = IDW'(rr_next(32'(idx), NUM_MASTERS));
        end
        if (lock_q) begin
            sel = lock_id_q;
        end
    end

    // Full FIFO blocks requests even when a pop happens now.
    assign s_req_o = !rst_i && m_req_i[sel] && !fifo_full;
    assign xfer    = s_req_o && s_gnt_i;
    assign pop     = !rst_i && s_rvalid_i && !fifo_empty;

    always_comb begin
        s_addr_o   = '0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_wdata_o  = '0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!rst_i && sel == IDW'(k)) begin
                s_addr_o  = m_addr_i[k*BUS_AW +: BUS_AW];
                s_we_o    = m_we_i[k];
                s_be_o    = m_be_i[k*BUS_BEW +: BUS_BEW];
                s_wdata_o = m_wdata_i[k*BUS_DW +: BUS_DW];
                m_gnt_o[k] = xfer;
            end
            if (fifo_head == IDW'(k)) begin
                m_rvalid_o[k] = pop;
            end
        end
    end

    assign m_rdata_o = rst_i ? '0 : {NUM_MASTERS{s_rdata_i}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (xfer) begin
                ptr_q  <= IDW'(rr_next(32'(sel), NUM_MASTERS));
                lock_q <= 1'b0;
            end else if (s_req_o) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end else if (lock_q && !m_req_i[lock_id_q]) begin
                lock_q <= 1'b0;
            end
            // Response with nothing outstanding: dropped, flagged.
            err_q <= err_q | (s_rvalid_i & fifo_empty);
        end
    end

    arb_id_fifo #(
        .W     (IDW),
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (xfer),
        .din_i   (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule
